// File: rtl/gpr_usr_n_pkg.sv
// Shared mode encodings and FSM states for the universal shift register.
package gpr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_MSH  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } gpr_state_e;

endpackage

// File: rtl/gpr_usr_n_if.sv
// Control, data and status bundle for gpr_usr_n; master drives, slave is the register.
interface gpr_usr_n_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             EN;
  logic [2:0]       S;
  logic             r_in;
  logic             l_in;
  logic [WIDTH-1:0] X;
  logic [CW-1:0]    AMT;
  logic             DIR;
  logic             START;
  logic [WIDTH-1:0] Q;
  logic             r_out;
  logic             l_out;
  logic             BUSY;
  logic             DONE;

  modport master (
    output EN, S, r_in, l_in, X, AMT, DIR, START,
    input  Q, r_out, l_out, BUSY, DONE
  );

  modport slave (
    input  EN, S, r_in, l_in, X, AMT, DIR, START,
    output Q, r_out, l_out, BUSY, DONE
  );

endinterface

// File: rtl/gpr_usr_n_shift_ctl.sv
// Multi-shift sequencer: saturating down-counter plus IDLE/SHIFT/FIN FSM.
// state    | meaning
// ST_IDLE  | single-cycle modes active, waiting for a multi-shift request
// ST_SHIFT | one logical shift per enabled edge, count decrements
// ST_FIN   | DONE asserted, returns to IDLE on next enabled edge
module gpr_shift_ctl
  import gpr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic          start_i,
  input  logic [CW-1:0] amt_i,
  input  logic          dir_i,
  output logic          shift_now_o,
  output logic          shift_dir_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [CW-1:0] AMT_MAX = CW'(WIDTH);

  gpr_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] amt_sat;

  assign amt_sat = (amt_i > AMT_MAX) ? AMT_MAX : amt_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else if (en_i) begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dir_d   = dir_i;
          count_d = amt_sat;
          state_d = (amt_sat == '0) ? ST_FIN : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign shift_now_o = (state_q == ST_SHIFT) && en_i;
  assign shift_dir_o = dir_q;
  assign busy_o      = (state_q == ST_SHIFT);
  assign done_o      = (state_q == ST_FIN);

endmodule

// File: rtl/gpr_usr_n.sv
// Universal WIDTH-bit shift register: single-cycle modes plus sequenced shift-by-N.
module gpr_usr_n
  import gpr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic          CLK,
  input logic          CLR,
  gpr_usr_n_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             shift_now, shift_dir, busy, done;
  logic             idle, start_req;

  assign idle      = !busy && !done;
  assign start_req = idle && (bus.S == MODE_MSH) && bus.START;

  gpr_shift_ctl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctl (
    .clk_i       (CLK),
    .rst_n_i     (CLR),
    .en_i        (bus.EN),
    .start_i     (start_req),
    .amt_i       (bus.AMT),
    .dir_i       (bus.DIR),
    .shift_now_o (shift_now),
    .shift_dir_o (shift_dir),
    .busy_o      (busy),
    .done_o      (done)
  );

  always_comb begin
    q_d = q_q;
    if (shift_now) begin
      q_d = shift_dir ? {q_q[WIDTH-2:0], 1'b0} : {1'b0, q_q[WIDTH-1:1]};
    end else if (idle) begin
      // MODE_MSH never alters Q in IDLE; acceptance only arms the sequencer
      unique case (bus.S)
        MODE_SHR:  q_d = {bus.r_in, q_q[WIDTH-1:1]};
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], bus.l_in};
        MODE_LOAD: q_d = bus.X;
        MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) q_q <= '0;
    else if (bus.EN) q_q <= q_d;
  end

  assign bus.Q     = q_q;
  assign bus.r_out = q_q[0];
  assign bus.l_out = q_q[WIDTH-1];
  assign bus.BUSY  = busy;
  assign bus.DONE  = done;

endmodule

// File: tb/tb_gpr_usr_n.sv
// Directed bench for gpr_usr_n at WIDTH=8 with hand-computed expectations.
module tb_gpr_usr_n;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic clr;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cnt;
  int   guard;

  always #5 clk = ~clk;

  gpr_usr_n_if #(.WIDTH(WIDTH)) bus ();

  gpr_usr_n #(.WIDTH(WIDTH)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    bus.S = 3'b011;
    bus.X = v;
    step();
    bus.S = 3'b000;
  endtask

  task automatic accept(input logic dir, input logic [3:0] amt);
    bus.S     = 3'b111;
    bus.START = 1'b1;
    bus.DIR   = dir;
    bus.AMT   = amt;
    step();
    bus.S     = 3'b000;
    bus.START = 1'b0;
  endtask

  initial begin
    clr = 1'b0;
    bus.EN = 1'b1; bus.S = 3'b000; bus.r_in = 1'b0; bus.l_in = 1'b0;
    bus.X = '0; bus.AMT = '0; bus.DIR = 1'b0; bus.START = 1'b0;
    step();
    chk("rst_q", bus.Q, 8'h00);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    clr = 1'b1;

    load(8'hA5);
    chk("load_a5", bus.Q, 8'hA5);
    bus.EN = 1'b0; bus.S = 3'b001; bus.r_in = 1'b1;
    repeat (3) step();
    chk("en0_hold", bus.Q, 8'hA5);
    bus.EN = 1'b1; bus.S = 3'b000;

    load(8'h81);
    chk("r_out", bus.r_out, 1'b1);
    chk("l_out", bus.l_out, 1'b1);
    bus.S = 3'b001; bus.r_in = 1'b1; step(); chk("shr", bus.Q, 8'hC0);
    load(8'h81);
    bus.S = 3'b010; bus.l_in = 1'b1; step(); chk("shl", bus.Q, 8'h03);
    load(8'h81);
    bus.S = 3'b100; step(); chk("ror", bus.Q, 8'hC0);
    load(8'h81);
    bus.S = 3'b101; step(); chk("rol", bus.Q, 8'h03);
    load(8'h81);
    bus.S = 3'b110; step(); chk("asr", bus.Q, 8'hC0);
    bus.S = 3'b111; bus.START = 1'b0; step();
    chk("msh_nostart_q", bus.Q, 8'hC0);
    chk("msh_nostart_busy", bus.BUSY, 1'b0);
    bus.S = 3'b000; bus.r_in = 1'b0; bus.l_in = 1'b0;

    // shift-left by 3
    load(8'h0F);
    accept(1'b1, 4'd3);
    chk("ml_acc_q", bus.Q, 8'h0F);
    chk("ml_acc_busy", bus.BUSY, 1'b1);
    step(); chk("ml_q1", bus.Q, 8'h1E); chk("ml_busy1", bus.BUSY, 1'b1);
    step(); chk("ml_q2", bus.Q, 8'h3C); chk("ml_busy2", bus.BUSY, 1'b1);
    step(); chk("ml_q3", bus.Q, 8'h78); chk("ml_busy3", bus.BUSY, 1'b0);
    chk("ml_done", bus.DONE, 1'b1);
    step(); chk("ml_done_clr", bus.DONE, 1'b0); chk("ml_q_end", bus.Q, 8'h78);

    // zero amount
    accept(1'b0, 4'd0);
    chk("z_busy", bus.BUSY, 1'b0);
    chk("z_done", bus.DONE, 1'b1);
    chk("z_q", bus.Q, 8'h78);
    step(); chk("z_done_clr", bus.DONE, 1'b0);

    // saturated right shift with ignored inputs during BUSY and FIN
    load(8'hFF);
    accept(1'b0, 4'd15);
    bus.START = 1'b1; bus.S = 3'b011; bus.X = 8'h55;
    cnt = 0; guard = 0;
    while (bus.BUSY && guard < 40) begin
      cnt++; guard++;
      step();
    end
    chk("sat_busy_cycles", cnt, 8);
    chk("sat_done", bus.DONE, 1'b1);
    chk("sat_q", bus.Q, 8'h00);
    step();
    chk("fin_noqueue_busy", bus.BUSY, 1'b0);
    chk("fin_noqueue_done", bus.DONE, 1'b0);
    chk("fin_noqueue_q", bus.Q, 8'h00);
    bus.S = 3'b000; bus.START = 1'b0;

    // abort by reset during second SHIFT cycle
    load(8'hF0);
    accept(1'b0, 4'd4);
    step(); chk("ab_q1", bus.Q, 8'h78);
    clr = 1'b0; step(); clr = 1'b1;
    chk("ab_q", bus.Q, 8'h00);
    chk("ab_busy", bus.BUSY, 1'b0);
    cnt = 0;
    repeat (4) begin
      if (bus.DONE) cnt++;
      step();
    end
    chk("ab_no_done", cnt, 0);

    // EN stall mid-shift
    load(8'h80);
    accept(1'b0, 4'd3);
    cnt = 1;
    step(); cnt++; chk("st_q1", bus.Q, 8'h40);
    bus.EN = 1'b0;
    step(); if (bus.BUSY) cnt++;
    step(); if (bus.BUSY) cnt++;
    chk("st_frozen_q", bus.Q, 8'h40);
    bus.EN = 1'b1;
    guard = 0;
    step();
    while (bus.BUSY && guard < 20) begin
      cnt++; guard++;
      step();
    end
    chk("st_busy_total", cnt, 5);
    chk("st_q_end", bus.Q, 8'h10);
    chk("st_done", bus.DONE, 1'b1);
    bus.EN = 1'b0; step();
    chk("st_done_stretch", bus.DONE, 1'b1);
    bus.EN = 1'b1; step();
    chk("st_done_clr", bus.DONE, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/gpr_usr_n.md
Name: gpr_usr_n

Overview:
- Parametrised universal shift register. Successor to the 4-bit GPR, generalised to WIDTH bits.
- Adds rotate, arithmetic-shift and serial-out modes to the classic hold/shift-right/shift-left/load set.
- Adds a multi-cycle shift-by-N operation with a start/busy/done handshake.
- Serves as a general register in the lab datapath and as the shifter for sequential multiply/divide blocks.

Parameters:
- WIDTH, 8, register width in bits (legal range 2..64).
- CW, $clog2(WIDTH)+1, width of the shift-amount field (derived; not for override).

Ports:
- CLK    input   1      rising-edge clock
- CLR    input   1      reset; synchronous, active-low
- EN     input   1      clock enable for all register and FSM updates
- S      input   3      mode select (encodings under Behaviour)
- r_in   input   1      serial input entering the MSB on shift right
- l_in   input   1      serial input entering the LSB on shift left
- X      input   WIDTH  parallel load data
- AMT    input   CW     shift amount for multi-shift
- DIR    input   1      multi-shift direction: 0 = right, 1 = left
- START  input   1      multi-shift request
- Q      output  WIDTH  register contents
- r_out  output  1      Q[0] (bit lost on a right shift)
- l_out  output  1      Q[WIDTH-1] (bit lost on a left shift)
- BUSY   output  1      multi-shift in progress
- DONE   output  1      one-cycle pulse when multi-shift completes

Behaviour:
- Reset: CLR=0 at a rising edge sets Q=0, FSM=IDLE, BUSY=0, DONE=0 and count=0. CLR overrides EN. Reset mid multi-shift aborts it and no DONE is produced.
- EN=0: all state frozen, including FSM and count. DONE holds its value, so a pending DONE pulse is stretched until EN returns.
- Modes, with effect on Q one edge later (IDLE, EN=1):
  - 000 hold
  - 001 shift right: {r_in, Q[W-1:1]}
  - 010 shift left: {Q[W-2:0], l_in}
  - 011 load X
  - 100 rotate right: {Q[0], Q[W-1:1]}
  - 101 rotate left: {Q[W-2:0], Q[W-1]}
  - 110 arithmetic right: {Q[W-1], Q[W-1:1]}
  - 111 multi-shift (below)
- S=111 with START=0: hold.
- FSM states: IDLE, SHIFT, FIN.
- IDLE, EN=1, S=111, START=1 (acceptance edge):
  - Latch dir=DIR and count=min(AMT, WIDTH).
  - If the saturated amount is 0, go to FIN. Otherwise go to SHIFT.
  - Q is unchanged on the acceptance edge.
- SHIFT, EN=1: shift one bit per edge, logical with zero fill (right: {0,Q[W-1:1]}; left: {Q[W-2:0],0}). Decrement count. When count==1 before the edge, go to FIN.
- FIN: DONE=1 for one cycle, then IDLE on the next EN=1 edge.
- BUSY=1 exactly while in SHIFT. DONE=1 exactly while in FIN.
- Latency: AMT=k≥1 gives BUSY high for k cycles, then DONE in cycle k+1 after acceptance. AMT=0 gives DONE in the cycle after acceptance with no BUSY.
- While in SHIFT or FIN, S, X, r_in, l_in, AMT, DIR and START are ignored. START in FIN is not queued.
- AMT>WIDTH saturates to WIDTH, so Q becomes 0.
- r_out and l_out are combinational from Q and always valid.

Decomposition:
- Package gpr_pkg holds:
  - mode localparams: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_ASR, MODE_MSH
  - FSM state encodings: ST_IDLE, ST_SHIFT, ST_FIN
- One sub-module, gpr_shift_ctl, holds the FSM and down-counter. It outputs shift_now, shift_dir, BUSY and DONE. The top level holds the Q register and mode mux.

Test Plan (WIDTH=8):
- Reset and load: CLR=0 for 1 edge → Q=0x00, BUSY=0, DONE=0. Then S=011, X=0xA5 → Q=0xA5. Then EN=0, S=001 for 3 edges → Q stays 0xA5.
- Single-cycle modes from Q=0x81, one edge each:
  - S=001, r_in=1 → 0xC0
  - S=010, l_in=1 → 0x03
  - S=100 → 0xC0
  - S=101 → 0x03
  - S=110 → 0xC0
  - r_out=1 and l_out=1 at Q=0x81.
- Multi-shift left: Q=0x0F, S=111, START=1, DIR=1, AMT=3 → BUSY high 3 cycles, Q 0x1E→0x3C→0x78, then DONE pulse 1 cycle, then IDLE.
- Boundaries:
  - AMT=0 → DONE the cycle after acceptance, BUSY never high, Q unchanged.
  - AMT=15 with Q=0xFF, DIR=0 → 8 BUSY cycles, Q=0x00.
  - START and S=011 driven during BUSY → ignored.
- Abort: CLR=0 during 2nd SHIFT cycle → next edge Q=0x00, IDLE, no DONE pulse. EN=0 for 2 cycles mid-SHIFT → count and Q frozen, total BUSY cycles = AMT+2.
